pipe_ctrl_md: RTL and testbench

PIPE_CTRL_MD -- requirements
Module: pipe_ctrl_md

---
 rtl/pipe_ctrl_md_pkg.sv | 27 ++
 rtl/pipe_ctrl_md_if.sv | 30 +++
 rtl/pipe_ctrl_md_flopenrc.sv | 26 ++
 rtl/pipe_ctrl_md.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl_md.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_md_pkg.sv
// Shared encodings for the pipeline controller: mult/div op codes,
// sequencer state type and a helper that sizes the latency down-counter.
package pipe_ctrl_md_pkg;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_RSVD = 2'b11
  } mdop_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  // Counter width: clog2 of the longer latency, never narrower than one bit.
  function automatic int cnt_width(input int mul_lat, input int div_lat);
    int longest;
    int w;
    longest = (mul_lat > div_lat) ? mul_lat : div_lat;
    w = $clog2(longest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_ctrl_md_if.sv
// Decode/execute/memory/writeback control bundle plus the mult/div handshake.
// master drives the decode-side inputs and hazard controls; slave is the
// pipeline controller.
interface pipe_ctrl_md_if #(
  parameter int CW = 16
);
  logic [CW-1:0] ctrlD;
  logic [1:0]    mdopD;
  logic          stallE;
  logic          flushE;
  logic          flushM;
  logic [CW-1:0] ctrlE;
  logic [CW-1:0] ctrlM;
  logic [CW-1:0] ctrlW;
  logic [1:0]    mdopE;
  logic          md_start;
  logic          md_done;
  logic          md_busy;
  logic          stall_req;

  modport master (
    output ctrlD, mdopD, stallE, flushE, flushM,
    input  ctrlE, ctrlM, ctrlW, mdopE, md_start, md_done, md_busy, stall_req
  );

  modport slave (
    input  ctrlD, mdopD, stallE, flushE, flushM,
    output ctrlE, ctrlM, ctrlW, mdopE, md_start, md_done, md_busy, stall_req
  );
endinterface

// File: rtl/pipe_ctrl_md_flopenrc.sv
// Pipeline register with enable and synchronous clear.
// Priority: rst > clr > en.
module flopenrc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage register: reset and clear both load zero, otherwise load when enabled.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_md.sv
// Execute/memory/writeback control pipeline with a multi-cycle mult/div
// sequencer. The sequencer holds the front of the pipe (stall_req) while a
// mult/div occupies execute and bubbles the memory stage meanwhile.
module pipe_ctrl_md
  import pipe_ctrl_md_pkg::*;
#(
  parameter int CW      = 16,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input logic           clk,
  input logic           rst,
  pipe_ctrl_md_if.slave bus
);

  localparam int CNTW = cnt_width(MUL_LAT, DIV_LAT);
  // Counter preload: counts the busy cycles between the start and done cycles.
  localparam logic [CNTW-1:0] MUL_INIT = CNTW'(MUL_LAT - 2);
  localparam logic [CNTW-1:0] DIV_INIT = CNTW'(DIV_LAT - 2);

  state_t          state, state_next;
  logic [CNTW-1:0] cnt, cnt_next;
  logic            md_start, md_done, stall_req;
  logic [CW+1:0]   e_d, e_q;
  logic [CW-1:0]   ctrl_m, ctrl_w;
  mdop_t           op_e;
  logic            is_md, lat_one;
  logic [CNTW-1:0] cnt_init;

  // ---------------- stage registers ----------------
  assign e_d = {bus.mdopD, bus.ctrlD};

  flopenrc #(.WIDTH(CW + 2)) u_reg_e (
    .clk (clk),
    .rst (rst),
    .en  (!(bus.stallE || stall_req)),
    .clr (bus.flushE),
    .d   (e_d),
    .q   (e_q)
  );

  // While execute is held by the sequencer, memory receives bubbles.
  flopenrc #(.WIDTH(CW)) u_reg_m (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (bus.flushM || stall_req),
    .d   (e_q[CW-1:0]),
    .q   (ctrl_m)
  );

  flopenrc #(.WIDTH(CW)) u_reg_w (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (1'b0),
    .d   (ctrl_m),
    .q   (ctrl_w)
  );

  assign op_e     = mdop_t'(e_q[CW+1:CW]);
  assign is_md    = (op_e == MD_MUL) || (op_e == MD_DIV);
  assign lat_one  = (op_e == MD_MUL) ? (MUL_LAT == 1) : (DIV_LAT == 1);
  assign cnt_init = (op_e == MD_MUL) ? MUL_INIT : DIV_INIT;

  // ---------------- sequencer ----------------
  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and handshake outputs; HOLD keeps md_done up without restarting.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_next = state;
    cnt_next   = cnt;
    md_start   = 1'b0;
    md_done    = 1'b0;
    stall_req  = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_md) begin
          md_start = 1'b1;
          if (lat_one) begin
            md_done = 1'b1;
            if (bus.stallE) state_next = S_HOLD;
          end else begin
            stall_req  = 1'b1;
            cnt_next   = cnt_init;
            state_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cnt != '0) begin
          stall_req = 1'b1;
          cnt_next  = cnt - 1'b1;
        end else begin
          md_done    = !bus.flushE;
          state_next = bus.stallE ? S_HOLD : S_IDLE;
        end
        if (bus.flushE) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      S_HOLD: begin
        md_done = !bus.flushE;
        if (!bus.stallE || bus.flushE) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign bus.ctrlE     = e_q[CW-1:0];
  assign bus.mdopE     = e_q[CW+1:CW];
  assign bus.ctrlM     = ctrl_m;
  assign bus.ctrlW     = ctrl_w;
  assign bus.md_start  = md_start;
  assign bus.md_done   = md_done;
  assign bus.md_busy   = (state != S_IDLE);
  assign bus.stall_req = stall_req;

endmodule

// File: tb/tb_pipe_ctrl_md.sv
// Bench for pipe_ctrl_md (CW=16, MUL_LAT=3, DIV_LAT=8): a per-cycle vector
// table for the plain pipeline, multiply and flush/stall behaviour, followed
// by hand-written divide sequences for hold, flush-abort and mid-op reset.
module tb_pipe_ctrl_md;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_md_if #(.CW(16)) bus ();

  pipe_ctrl_md #(.CW(16), .MUL_LAT(3), .DIV_LAT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // flags = {md_start, md_done, md_busy, stall_req}
  typedef struct {
    logic        stall_e;
    logic        flush_e;
    logic        flush_m;
    logic [15:0] ctrl_d;
    logic [1:0]  mdop_d;
    logic [15:0] ctrl_e;
    logic [1:0]  mdop_e;
    logic [15:0] ctrl_m;
    logic [15:0] ctrl_w;
    logic [3:0]  flags;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs away from the rising edge, then settle.
  task automatic cyc(input logic r, input logic st, input logic fe, input logic fm,
                     input logic [15:0] cd, input logic [1:0] md);
    @(negedge clk);
    rst        = r;
    bus.stallE = st;
    bus.flushE = fe;
    bus.flushM = fm;
    bus.ctrlD  = cd;
    bus.mdopD  = md;
    #1;
  endtask

  function automatic logic [3:0] flags();
    return {bus.md_start, bus.md_done, bus.md_busy, bus.stall_req};
  endfunction

  logic [15:0] start_m, done_m, busy_m, sreq_m;

  initial begin
    //            st fe fm ctrlD    md     ctrlE    mE     ctrlM    ctrlW    flags
    vecs[0]  = '{0, 0, 0, 16'hA5A5, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000};
    vecs[1]  = '{0, 0, 0, 16'h0011, 2'b01, 16'hA5A5, 2'b00, 16'h0000, 16'h0000, 4'b0000};
    vecs[2]  = '{0, 0, 0, 16'h0000, 2'b00, 16'h0011, 2'b01, 16'hA5A5, 16'h0000, 4'b1001};
    vecs[3]  = '{0, 0, 0, 16'h0000, 2'b00, 16'h0011, 2'b01, 16'h0000, 16'hA5A5, 4'b0011};
    vecs[4]  = '{0, 0, 0, 16'h0000, 2'b00, 16'h0011, 2'b01, 16'h0000, 16'h0000, 4'b0110};
    vecs[5]  = '{0, 0, 0, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h0011, 16'h0000, 4'b0000};
    vecs[6]  = '{0, 0, 0, 16'hFFFF, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0011, 4'b0000};
    vecs[7]  = '{1, 1, 0, 16'h1234, 2'b00, 16'hFFFF, 2'b00, 16'h0000, 16'h0000, 4'b0000};
    vecs[8]  = '{0, 0, 0, 16'h1234, 2'b11, 16'h0000, 2'b00, 16'hFFFF, 16'h0000, 4'b0000};
    vecs[9]  = '{0, 0, 1, 16'h0000, 2'b00, 16'h1234, 2'b11, 16'h0000, 16'hFFFF, 4'b0000};
    vecs[10] = '{0, 0, 0, 16'h5555, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000};
    vecs[11] = '{1, 0, 0, 16'h6666, 2'b00, 16'h5555, 2'b00, 16'h0000, 16'h0000, 4'b0000};
    vecs[12] = '{0, 0, 0, 16'h6666, 2'b00, 16'h5555, 2'b00, 16'h5555, 16'h0000, 4'b0000};
    vecs[13] = '{0, 0, 0, 16'h0000, 2'b00, 16'h6666, 2'b00, 16'h5555, 16'h5555, 4'b0000};
    vecs[14] = '{0, 0, 0, 16'h0000, 2'b00, 16'h0000, 2'b00, 16'h6666, 16'h5555, 4'b0000};

    bus.stallE = 1'b0;
    bus.flushE = 1'b0;
    bus.flushM = 1'b0;
    bus.ctrlD  = '0;
    bus.mdopD  = '0;
    repeat (3) @(posedge clk);
    cyc(0, 0, 0, 0, 16'h0000, 2'b00);
    check("reset ctrlE", {16'h0, bus.ctrlE}, 32'h0);
    check("reset ctrlW", {16'h0, bus.ctrlW}, 32'h0);
    check("reset flags", {28'h0, flags()}, 32'h0);

    // Table: one row per cycle, expected outputs for that same cycle.
    for (int i = 0; i < NV; i++) begin
      cyc(0, vecs[i].stall_e, vecs[i].flush_e, vecs[i].flush_m, vecs[i].ctrl_d, vecs[i].mdop_d);
      check($sformatf("row%0d ctrlE", i), {16'h0, bus.ctrlE}, {16'h0, vecs[i].ctrl_e});
      check($sformatf("row%0d mdopE", i), {30'h0, bus.mdopE}, {30'h0, vecs[i].mdop_e});
      check($sformatf("row%0d ctrlM", i), {16'h0, bus.ctrlM}, {16'h0, vecs[i].ctrl_m});
      check($sformatf("row%0d ctrlW", i), {16'h0, bus.ctrlW}, {16'h0, vecs[i].ctrl_w});
      check($sformatf("row%0d flags", i), {28'h0, flags()}, {28'h0, vecs[i].flags});
    end

    // Divide with stallE high on the done cycle and the one after.
    start_m = '0; done_m = '0; busy_m = '0; sreq_m = '0;
    for (int k = 0; k <= 12; k++) begin
      cyc(0, (k == 8 || k == 9), 0, 0, (k == 0) ? 16'h0D0D : 16'h0000,
          (k == 0) ? 2'b10 : 2'b00);
      start_m[k] = bus.md_start;
      done_m[k]  = bus.md_done;
      busy_m[k]  = bus.md_busy;
      sreq_m[k]  = bus.stall_req;
      if (k == 10) check("div hold ctrlE", {16'h0, bus.ctrlE}, 32'h0000_0D0D);
    end
    check("div hold start", {16'h0, start_m}, 32'h0000_0002);
    check("div hold stall_req", {16'h0, sreq_m}, 32'h0000_00FE);
    check("div hold done", {16'h0, done_m}, 32'h0000_0700);
    check("div hold busy", {16'h0, busy_m}, 32'h0000_07FC);

    // Divide aborted by flushE on the fourth execute cycle.
    done_m = '0; busy_m = '0;
    for (int k = 0; k <= 8; k++) begin
      cyc(0, 0, (k == 4), 0, (k == 0) ? 16'hBEEF : 16'h0000,
          (k == 0) ? 2'b10 : 2'b00);
      done_m[k] = bus.md_done;
      busy_m[k] = bus.md_busy;
      if (k == 5) begin
        check("div flush ctrlE", {16'h0, bus.ctrlE}, 32'h0);
        check("div flush busy", {31'h0, bus.md_busy}, 32'h0);
        check("div flush stall_req", {31'h0, bus.stall_req}, 32'h0);
      end
    end
    check("div flush done", {16'h0, done_m}, 32'h0);
    check("div flush busy span", {16'h0, busy_m}, 32'h0000_001C);

    // Reset in the middle of a divide.
    for (int k = 0; k <= 6; k++) begin
      cyc((k == 5), 0, 0, 0, (k == 0) ? 16'hC3C3 : 16'h0000,
          (k == 0) ? 2'b10 : 2'b00);
      if (k == 4) check("div rst busy before", {31'h0, bus.md_busy}, 32'h1);
      if (k == 6) begin
        check("div rst ctrlE", {16'h0, bus.ctrlE}, 32'h0);
        check("div rst mdopE", {30'h0, bus.mdopE}, 32'h0);
        check("div rst ctrlM", {16'h0, bus.ctrlM}, 32'h0);
        check("div rst ctrlW", {16'h0, bus.ctrlW}, 32'h0);
        check("div rst flags", {28'h0, flags()}, 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
